writeback_stage: RTL and testbench

//  MEM/WB pipeline register plus writeback logic. Sits directly downstream of mem_stage
//  and consumes its outputs: RegWriteM, MemtoRegM, RD, ALUOutM and WriteRegM.
//  Its jobs:
//  - extract sub-word loads;
//  - select the result driven to the register file;
//  - keep a one-entry bypass of the previous writeback for decode-stage forwarding;
//  - count retired instructions.

---
 rtl/writeback_stage.sv | 151 +++++++++++++++
 tb/tb_writeback_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// writeback_stage : MEM/WB register, sub-word load extraction, bypass entry
// and retired-instruction counter. Optional trace under WB_TRACE_EN. Rev 1.0
// ---------------------------------------------------------------------------
module writeback_stage #(
  parameter int COUNT_W    = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallW,
  input  logic               FlushW,
  input  logic               ValidM,
  input  logic               RegWriteM,
  input  logic               MemtoRegM,
  input  logic [2:0]         LoadTypeM,
  input  logic [31:0]        RD,
  input  logic [31:0]        ALUOutM,
  input  logic [4:0]         WriteRegM,
  output logic               ValidW,
  output logic               RegWriteW,
  output logic [4:0]         WriteRegW,
  output logic [31:0]        ResultW,
  output logic               AlignErrW,
  output logic               HoldValidW,
  output logic [4:0]         HoldRegW,
  output logic [31:0]        HoldResultW,
  output logic [COUNT_W-1:0] RetiredW
);

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic               wb_valid;
  logic               wb_regwrite;
  logic               wb_memtoreg;
  logic [2:0]         wb_loadtype;
  logic [31:0]        wb_rd;
  logic [31:0]        wb_aluout;
  logic [4:0]         wb_writereg;
  logic [1:0]         wb_offset;
  logic               hold_valid;
  logic [4:0]         hold_reg;
  logic [31:0]        hold_result;
  logic [COUNT_W-1:0] retired;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        result;
  logic               is_half;

  // A flush takes priority over a stall, so a flushing edge still retires W
  // and refreshes the bypass entry with the pre-flush contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_loadtype <= 3'b000;
      wb_rd       <= 32'd0;
      wb_aluout   <= 32'd0;
      wb_writereg <= 5'd0;
      wb_offset   <= 2'd0;
      hold_valid  <= 1'b0;
      hold_reg    <= 5'd0;
      hold_result <= 32'd0;
      retired     <= '0;
    end else if (FlushW || !StallW) begin
      hold_valid  <= RegWriteW;
      hold_reg    <= wb_writereg;
      hold_result <= result;
      retired     <= retired + {{(COUNT_W-1){1'b0}}, wb_valid};
      if (FlushW) begin
        wb_valid    <= 1'b0;
        wb_regwrite <= 1'b0;
      end else begin
        wb_valid    <= ValidM;
        wb_regwrite <= RegWriteM;
        wb_memtoreg <= MemtoRegM;
        wb_loadtype <= LoadTypeM;
        wb_rd       <= RD;
        wb_aluout   <= ALUOutM;
        wb_writereg <= WriteRegM;
        wb_offset   <= ALUOutM[1:0];
      end
    end
  end

  generate
    if (BIG_ENDIAN) begin : g_big_endian
      always_comb begin
        case (wb_offset)
          2'd0:    byte_sel = wb_rd[31:24];
          2'd1:    byte_sel = wb_rd[23:16];
          2'd2:    byte_sel = wb_rd[15:8];
          default: byte_sel = wb_rd[7:0];
        endcase
        half_sel = wb_offset[1] ? wb_rd[15:0] : wb_rd[31:16];
      end
    end else begin : g_little_endian
      always_comb begin
        case (wb_offset)
          2'd0:    byte_sel = wb_rd[7:0];
          2'd1:    byte_sel = wb_rd[15:8];
          2'd2:    byte_sel = wb_rd[23:16];
          default: byte_sel = wb_rd[31:24];
        endcase
        half_sel = wb_offset[1] ? wb_rd[31:16] : wb_rd[15:0];
      end
    end
  endgenerate

  always_comb begin
    result = wb_aluout;
    if (wb_memtoreg) begin
      case (wb_loadtype)
        LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
        LT_LBU:  result = {24'd0, byte_sel};
        LT_LH:   result = {{16{half_sel[15]}}, half_sel};
        LT_LHU:  result = {16'd0, half_sel};
        default: result = wb_rd;
      endcase
    end
  end

  assign is_half     = (wb_loadtype == LT_LH) || (wb_loadtype == LT_LHU);
  assign ValidW      = wb_valid;
  assign RegWriteW   = wb_valid & wb_regwrite & (wb_writereg != 5'd0);
  assign WriteRegW   = wb_writereg;
  assign ResultW     = result;
  assign AlignErrW   = wb_valid & wb_memtoreg & is_half & wb_offset[0];
  assign HoldValidW  = hold_valid;
  assign HoldRegW    = hold_reg;
  assign HoldResultW = hold_result;
  assign RetiredW    = retired;

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (RegWriteW && !StallW)
        $display("WB r%0d <= %h", WriteRegW, ResultW);
      if (AlignErrW)
        $display("WB warning: misaligned halfword load, offset %0d", wb_offset);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_writeback_stage : directed + random bench against a behavioural model.
// ---------------------------------------------------------------------------
module tb_writeback_stage;
  localparam int CW = 4;
  localparam bit BE = 1'b1;

  logic          clk = 1'b0;
  logic          reset, StallW, FlushW, ValidM, RegWriteM, MemtoRegM;
  logic [2:0]    LoadTypeM;
  logic [31:0]   RD, ALUOutM;
  logic [4:0]    WriteRegM;
  logic          ValidW, RegWriteW, AlignErrW, HoldValidW;
  logic [4:0]    WriteRegW, HoldRegW;
  logic [31:0]   ResultW, HoldResultW;
  logic [CW-1:0] RetiredW;

  always #5 clk = ~clk;

  writeback_stage #(.COUNT_W(CW), .BIG_ENDIAN(BE)) dut (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .LoadTypeM(LoadTypeM), .RD(RD), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM),
    .ValidW(ValidW), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .AlignErrW(AlignErrW), .HoldValidW(HoldValidW),
    .HoldRegW(HoldRegW), .HoldResultW(HoldResultW), .RetiredW(RetiredW)
  );

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic [2:0]  lt;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
  } ent_t;

  ent_t        mw;
  bit          mw_known;
  bit          mh_valid;
  logic [4:0]  mh_reg;
  logic [31:0] mh_res;
  bit          mh_known;
  int          mcnt;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte lane number counted from the LSB: big-endian offset 0 is the top byte.
  function automatic logic [31:0] m_result(input ent_t e);
    int          lane;
    logic [7:0]  b;
    logic [15:0] h;
    if (!e.m2r) return e.alu;
    case (e.lt)
      3'd1, 3'd2: begin
        lane = BE ? 3 - int'(e.alu[1:0]) : int'(e.alu[1:0]);
        b = 8'(e.rd >> (8 * lane));
        return (e.lt == 3'd1) ? {{24{b[7]}}, b} : {24'd0, b};
      end
      3'd3, 3'd4: begin
        lane = (BE ? !e.alu[1] : e.alu[1]) ? 2 : 0;
        h = 16'(e.rd >> (8 * lane));
        return (e.lt == 3'd3) ? {{16{h[15]}}, h} : {16'd0, h};
      end
      default: return e.rd;
    endcase
  endfunction

  function automatic logic m_regwrite(input ent_t e);
    return e.valid && e.rw && (e.wr != 5'd0);
  endfunction

  function automatic logic m_alerr(input ent_t e);
    return e.valid && e.m2r && (e.lt == 3'd3 || e.lt == 3'd4) && e.alu[0];
  endfunction

  task automatic step();
    ent_t in;
    in = '{ValidM, RegWriteM, MemtoRegM, LoadTypeM, RD, ALUOutM, WriteRegM};
    if (reset) begin
      mw = '0; mw_known = 1; mh_valid = 0; mh_reg = 0; mh_res = 0; mh_known = 1; mcnt = 0;
    end else if (FlushW || !StallW) begin
      mh_valid = m_regwrite(mw);
      mh_reg   = mw.wr;
      mh_res   = m_result(mw);
      mh_known = mw_known;
      mcnt     = (mcnt + (mw.valid ? 1 : 0)) % (1 << CW);
      if (FlushW) begin
        mw.valid = 1'b0; mw.rw = 1'b0; mw_known = 0;
      end else begin
        mw = in; mw_known = 1;
      end
    end
    @(posedge clk);
    #1;
    check("valid", 32'(ValidW), 32'(mw.valid));
    check("regwrite", 32'(RegWriteW), 32'(m_regwrite(mw)));
    check("alignerr", 32'(AlignErrW), 32'(m_alerr(mw)));
    check("retired", 32'(RetiredW), 32'(mcnt));
    check("holdvalid", 32'(HoldValidW), 32'(mh_valid));
    if (mw_known) begin
      check("writereg", 32'(WriteRegW), 32'(mw.wr));
      check("result", ResultW, m_result(mw));
    end
    if (mh_known) begin
      check("holdreg", 32'(HoldRegW), 32'(mh_reg));
      check("holdresult", HoldResultW, mh_res);
    end
  endtask

  task automatic rand_m();
    ValidM    = 1'($urandom);
    RegWriteM = 1'($urandom);
    MemtoRegM = 1'($urandom);
    LoadTypeM = 3'($urandom);
    RD        = $urandom;
    ALUOutM   = $urandom;
    WriteRegM = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
  endtask

  task automatic set_m(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr);
    ValidM = v; RegWriteM = rw; MemtoRegM = m2r; LoadTypeM = lt;
    RD = rd; ALUOutM = alu; WriteRegM = wr;
  endtask

  initial begin
    logic [31:0] saved_res;
    int          saved_cnt;
    reset = 1'b1; StallW = 1'b0; FlushW = 1'b0;
    rand_m();

    // Reset with arbitrary inputs
    step(); rand_m(); StallW = 1'b1; step();
    check("rst_valid", 32'(ValidW), 32'd0);
    check("rst_regwrite", 32'(RegWriteW), 32'd0);
    check("rst_result", ResultW, 32'd0);
    check("rst_retired", 32'(RetiredW), 32'd0);
    check("rst_holdvalid", 32'(HoldValidW), 32'd0);

    // ALU path
    reset = 1'b0; StallW = 1'b0;
    set_m(1, 1, 0, 3'd0, 32'hDEAD_BEEF, 32'h1234, 5'd5);
    step();
    check("alu_regwrite", 32'(RegWriteW), 32'd1);
    check("alu_writereg", 32'(WriteRegW), 32'd5);
    check("alu_result", ResultW, 32'h1234);
    set_m(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
    check("alu_holdreg", 32'(HoldRegW), 32'd5);
    check("alu_holdresult", HoldResultW, 32'h1234);
    check("alu_retired", 32'(RetiredW), 32'd1);

    // Sub-word loads
    set_m(1, 1, 1, 3'd1, 32'h80FF_7F01, 32'h401, 5'd7); step();
    check("lb_result", ResultW, 32'hFFFF_FFFF);
    set_m(1, 1, 1, 3'd2, 32'h80FF_7F01, 32'h400, 5'd7); step();
    check("lbu_result", ResultW, 32'h0000_0080);
    set_m(1, 1, 1, 3'd3, 32'h80FF_7F01, 32'h402, 5'd7); step();
    check("lh_result", ResultW, 32'h0000_7F01);
    check("lh_aligned", 32'(AlignErrW), 32'd0);
    set_m(1, 1, 1, 3'd3, 32'h80FF_7F01, 32'h403, 5'd7); step();
    check("lh_misaligned", 32'(AlignErrW), 32'd1);
    check("lh_mis_result", ResultW, 32'h0000_7F01);

    // Register $0 is never written but still retires
    set_m(1, 1, 0, 3'd0, 32'd0, 32'h55, 5'd0); step();
    check("r0_regwrite", 32'(RegWriteW), 32'd0);
    check("r0_valid", 32'(ValidW), 32'd1);
    saved_cnt = mcnt;
    set_m(1, 1, 0, 3'd0, 32'd0, 32'hABCD, 5'd9); step();
    check("r0_retired", 32'(RetiredW), 32'((saved_cnt + 1) % 16));

    // Stall holds everything, then flush beats stall
    saved_res = 32'hABCD;
    saved_cnt = mcnt;
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_m(); step();
      check("stall_result", ResultW, saved_res);
      check("stall_writereg", 32'(WriteRegW), 32'd9);
      check("stall_retired", 32'(RetiredW), 32'(saved_cnt));
    end
    FlushW = 1'b1; step();
    check("flush_valid", 32'(ValidW), 32'd0);
    check("flush_holdresult", HoldResultW, saved_res);
    FlushW = 1'b0; StallW = 1'b0;

    // Counter wrap: 17 retirements on a 4-bit counter
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      rand_m(); ValidM = 1'b1; step();
    end
    ValidM = 1'b0; step();
    check("wrap_retired", 32'(RetiredW), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rand_m();
      StallW = ($urandom_range(0, 4) == 0);
      FlushW = ($urandom_range(0, 9) == 0);
      reset  = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
